// File: rtl/bsg_cycle_counter_timestamper.sv
// Timestamps event pulses against a free-running cycle count and queues
// {stamp, delta, first} entries in a small FIFO with a saturating drop counter.
module bsg_cycle_counter_timestamper #(
    parameter int unsigned width_p      = 32,
    parameter int unsigned els_p        = 4,
    parameter int unsigned drop_width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [width_p-1:0]      ctr_i,
    input  logic                    event_i,
    output logic                    v_o,
    input  logic                    ready_i,
    output logic [width_p-1:0]      stamp_o,
    output logic [width_p-1:0]      delta_o,
    output logic                    first_o,
    output logic                    full_o,
    output logic [drop_width_p-1:0] drop_count_o
);

    localparam int unsigned ptr_w_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w_lp   = $clog2(els_p + 1);
    localparam int unsigned entry_w_lp = 2 * width_p + 1;

    localparam logic [cnt_w_lp-1:0] els_lp      = cnt_w_lp'(els_p);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

    logic [entry_w_lp-1:0]   mem_r [els_p];
    logic [ptr_w_lp-1:0]     rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0]     count_r;
    logic [width_p-1:0]      last_stamp_r;
    logic                    first_armed_r;
    logic [drop_width_p-1:0] drop_count_r;

    logic                    deq, acc, drop;
    logic [width_p-1:0]      delta;
    logic [entry_w_lp-1:0]   head;

    assign deq   = (count_r != '0) & ready_i;
    // A full FIFO still takes the event when the head leaves in the same cycle.
    assign acc   = event_i & ~reset_i & ((count_r < els_lp) | deq);
    assign drop  = event_i & ~reset_i & ~acc;
    assign delta = first_armed_r ? '0 : (ctr_i - last_stamp_r);

    always_ff @(posedge clk_i) begin
        if (acc) begin
            mem_r[wr_ptr_r] <= {ctr_i, delta, first_armed_r};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            last_stamp_r  <= '0;
            first_armed_r <= 1'b1;
            drop_count_r  <= '0;
        end else begin
            if (acc) begin
                wr_ptr_r      <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + ptr_w_lp'(1);
                last_stamp_r  <= ctr_i;
                first_armed_r <= 1'b0;
            end
            if (deq) begin
                rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + ptr_w_lp'(1);
            end
            case ({acc, deq})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
            if (drop && (drop_count_r != '1)) begin
                drop_count_r <= drop_count_r + drop_width_p'(1);
            end
        end
    end

    assign head         = mem_r[rd_ptr_r];
    assign stamp_o      = head[entry_w_lp-1 -: width_p];
    assign delta_o      = head[width_p:1];
    assign first_o      = head[0];
    assign v_o          = (count_r != '0);
    assign full_o       = (count_r == els_lp);
    assign drop_count_o = drop_count_r;

endmodule

// File: tb/tb_bsg_cycle_counter_timestamper.sv
// Directed bench for bsg_cycle_counter_timestamper: width 8, depth 4, 2-bit drop counter.
module tb_bsg_cycle_counter_timestamper;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] ctr_i;
    logic       event_i;
    logic       v_o;
    logic       ready_i;
    logic [7:0] stamp_o;
    logic [7:0] delta_o;
    logic       first_o;
    logic       full_o;
    logic [1:0] drop_count_o;

    int errors = 0;
    int checks = 0;

    bsg_cycle_counter_timestamper #(
        .width_p     (8),
        .els_p       (4),
        .drop_width_p(2)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ctr_i       (ctr_i),
        .event_i     (event_i),
        .v_o         (v_o),
        .ready_i     (ready_i),
        .stamp_o     (stamp_o),
        .delta_o     (delta_o),
        .first_o     (first_o),
        .full_o      (full_o),
        .drop_count_o(drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [7:0] s, input logic [7:0] d,
                            input logic f);
        chk({tag, ".v"}, 32'(v_o), 32'd1);
        chk({tag, ".stamp"}, 32'(stamp_o), 32'(s));
        chk({tag, ".delta"}, 32'(delta_o), 32'(d));
        chk({tag, ".first"}, 32'(first_o), 32'(f));
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        event_i = 1'b0;
        ready_i = 1'b0;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] c);
        ctr_i   = c;
        event_i = 1'b1;
        tick();
        event_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        event_i = 1'b0;
        ready_i = 1'b0;
        ctr_i   = 8'h00;
        tick();
        tick();
        reset_i = 1'b0;
        chk("rst.v", 32'(v_o), 32'd0);
        chk("rst.full", 32'(full_o), 32'd0);
        chk("rst.drop", 32'(drop_count_o), 32'd0);

        // Single event with consumer ready
        ready_i = 1'b1;
        pulse(8'h10);
        chk_head("single", 8'h10, 8'h00, 1'b1);
        tick();
        chk("single.empty", 32'(v_o), 32'd0);
        ready_i = 1'b0;

        // Deltas across counter wrap
        do_reset();
        pulse(8'hF0);
        pulse(8'hFA);
        pulse(8'h05);
        chk_head("wrap0", 8'hF0, 8'h00, 1'b1);
        ready_i = 1'b1;
        tick();
        chk_head("wrap1", 8'hFA, 8'h0A, 1'b0);
        tick();
        chk_head("wrap2", 8'h05, 8'h0B, 1'b0);
        tick();
        chk("wrap.empty", 32'(v_o), 32'd0);
        ready_i = 1'b0;

        // Backpressure and overflow
        do_reset();
        pulse(8'd1);
        pulse(8'd2);
        pulse(8'd3);
        chk("ovf.notfull", 32'(full_o), 32'd0);
        pulse(8'd4);
        chk("ovf.full", 32'(full_o), 32'd1);
        pulse(8'd5);
        pulse(8'd6);
        chk("ovf.drop", 32'(drop_count_o), 32'd2);
        chk("ovf.full2", 32'(full_o), 32'd1);
        chk_head("ovf0", 8'd1, 8'd0, 1'b1);

        // Full FIFO with simultaneous dequeue accepts the event
        ctr_i   = 8'd9;
        event_i = 1'b1;
        ready_i = 1'b1;
        tick();
        event_i = 1'b0;
        ready_i = 1'b0;
        chk("fdq.drop", 32'(drop_count_o), 32'd2);
        chk("fdq.full", 32'(full_o), 32'd1);
        chk_head("fdq1", 8'd2, 8'd1, 1'b0);
        ready_i = 1'b1;
        tick();
        chk_head("fdq2", 8'd3, 8'd1, 1'b0);
        tick();
        chk_head("fdq3", 8'd4, 8'd1, 1'b0);
        tick();
        chk_head("fdq4", 8'd9, 8'd5, 1'b0);
        tick();
        chk("fdq.empty", 32'(v_o), 32'd0);
        chk("fdq.nfull", 32'(full_o), 32'd0);
        ready_i = 1'b0;

        // ready with empty FIFO has no effect
        tick();
        chk("idle.v", 32'(v_o), 32'd0);

        // Drop counter saturation
        do_reset();
        pulse(8'd20);
        pulse(8'd21);
        pulse(8'd22);
        pulse(8'd23);
        pulse(8'd24);
        chk("sat1", 32'(drop_count_o), 32'd1);
        pulse(8'd25);
        chk("sat2", 32'(drop_count_o), 32'd2);
        pulse(8'd26);
        chk("sat3", 32'(drop_count_o), 32'd3);
        pulse(8'd27);
        pulse(8'd28);
        chk("sat5", 32'(drop_count_o), 32'd3);
        chk_head("sat.head", 8'd20, 8'd0, 1'b1);

        // Mid-operation reset with 3 entries buffered; event during reset is ignored
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("mid.nfull", 32'(full_o), 32'd0);
        chk_head("mid.pre", 8'd21, 8'd1, 1'b0);
        reset_i = 1'b1;
        ctr_i   = 8'h55;
        event_i = 1'b1;
        tick();
        reset_i = 1'b0;
        event_i = 1'b0;
        chk("mid.v", 32'(v_o), 32'd0);
        chk("mid.drop", 32'(drop_count_o), 32'd0);
        pulse(8'h77);
        chk_head("mid.first", 8'h77, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
